pipeline_ctrl: RTL

//  Central stall/flush sequencer for the 5-stage pipeline. Merges load-use stall (from hazard unit),
//  EX-stage branch redirect and multi-cycle data-memory wait into per-register enable/flush controls.

---
 rtl/pipeline_ctrl_pkg.sv | 27 ++
 rtl/pipeline_ctrl_if.sv | 34 +++
 rtl/pipeline_ctrl_checker.sv | 14 +
 rtl/pipeline_ctrl_sat_counter.sv | 25 ++
 rtl/pipeline_ctrl.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared state encodings and pipeline-control vector for the stall/flush sequencer.
package pipeline_ctrl_pkg;

  typedef logic [1:0] pctrl_state_t;

  localparam pctrl_state_t ST_RUN     = 2'd0;
  localparam pctrl_state_t ST_MEMWAIT = 2'd1;
  localparam pctrl_state_t ST_REDIR   = 2'd2;
  localparam pctrl_state_t ST_ERR     = 2'd3;

  typedef struct packed {
    logic pc_en;
    logic pc_redirect;
    logic ifid_en;
    logic ifid_flush;
    logic idex_en;
    logic idex_flush;
    logic exmem_en;
    logic memwb_en;
  } pipe_ctrl_t;

  // Free-running pipeline, fully frozen pipeline, and the held-in-reset pattern.
  localparam pipe_ctrl_t PIPE_RUN    = pipe_ctrl_t'(8'b1010_1011);
  localparam pipe_ctrl_t PIPE_FREEZE = pipe_ctrl_t'(8'b0000_0000);
  localparam pipe_ctrl_t PIPE_RESET  = pipe_ctrl_t'(8'b0001_0100);

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard/memory request inputs and per-register enable/flush outputs of the sequencer.
interface pipeline_ctrl_if #(
  parameter int CNT_W = 16
);

  logic             hz_stall;
  logic             ex_br_taken;
  logic             mem_req;
  logic             dmem_ready;
  logic             pc_en;
  logic             pc_redirect;
  logic             ifid_en;
  logic             ifid_flush;
  logic             idex_en;
  logic             idex_flush;
  logic             exmem_en;
  logic             memwb_en;
  logic             err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output hz_stall, ex_br_taken, mem_req, dmem_ready,
    input  pc_en, pc_redirect, ifid_en, ifid_flush, idex_en, idex_flush,
    input  exmem_en, memwb_en, err, stall_cnt, flush_cnt
  );

  modport slave (
    input  hz_stall, ex_br_taken, mem_req, dmem_ready,
    output pc_en, pc_redirect, ifid_en, ifid_flush, idex_en, idex_flush,
    output exmem_en, memwb_en, err, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/pipeline_ctrl_checker.sv
// Protocol checks for the sequencer's memory handshake.
module pipeline_ctrl_checker (
  input logic clk,
  input logic rst_n,
  input logic in_memwait,
  input logic mem_req,
  input logic dmem_ready
);

  // The MEM stage may not abandon an access the sequencer is still waiting on.
  assert property (@(posedge clk) disable iff (!rst_n)
                   (in_memwait && !dmem_ready) |-> mem_req);

endmodule

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter with synchronous active-low clear.
module pipeline_ctrl_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};
  localparam logic [W-1:0] CNT_ONE = W'(1);

  // Count up on inc, sticking at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= {W{1'b0}};
    end else if (inc && (q != CNT_MAX)) begin
      q <= q + CNT_ONE;
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer: merges load-use stall, EX redirect and dmem wait into
// per-register enables/flushes, with a memory timeout watchdog and perf counters.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int REDIRECT_CYC = 2,
  parameter int MEM_TIMEOUT  = 64,
  parameter int CNT_W        = 16
) (
  input logic             clk,
  input logic             rst_n,
  pipeline_ctrl_if.slave  ctl
);

  localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [1:0]        REDIR_INIT = 2'(REDIRECT_CYC - 1);

  pctrl_state_t      state_r, state_nxt_s;
  pctrl_state_t      ret_r, ret_nxt_s;
  logic [1:0]        redir_cnt_r, redir_nxt_s;
  logic [WAIT_W-1:0] wait_cnt_r, wait_nxt_s;
  logic              err_r, err_nxt_s;
  logic              flush_inc_s;
  logic              stall_inc_s;
  logic              mem_stall_s;
  pipe_ctrl_t        pipe_s;
  pipe_ctrl_t        pipe_out_s;
  logic [CNT_W-1:0]  stall_cnt_s;
  logic [CNT_W-1:0]  flush_cnt_s;

  assign mem_stall_s = ctl.mem_req & ~ctl.dmem_ready;

  // Next-state and control-vector decode; memory wait outranks branch outranks load-use.
  always_comb begin
    pipe_s      = PIPE_RUN;
    state_nxt_s = state_r;
    ret_nxt_s   = ret_r;
    redir_nxt_s = redir_cnt_r;
    wait_nxt_s  = wait_cnt_r;
    err_nxt_s   = err_r;
    flush_inc_s = 1'b0;
    case (state_r)
      ST_RUN: begin
        if (mem_stall_s) begin
          pipe_s      = PIPE_FREEZE;
          ret_nxt_s   = ST_RUN;
          state_nxt_s = ST_MEMWAIT;
          wait_nxt_s  = WAIT_ONE;
        end else if (ctl.ex_br_taken) begin
          pipe_s.pc_redirect = 1'b1;
          pipe_s.ifid_flush  = 1'b1;
          pipe_s.idex_flush  = 1'b1;
          flush_inc_s        = 1'b1;
          if (REDIRECT_CYC > 1) begin
            state_nxt_s = ST_REDIR;
            redir_nxt_s = REDIR_INIT;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end else if (ctl.hz_stall) begin
          pipe_s.pc_en      = 1'b0;
          pipe_s.ifid_en    = 1'b0;
          pipe_s.idex_flush = 1'b1;
        end else begin
          pipe_s = PIPE_RUN;
        end
      end
      ST_REDIR: begin
        // ID still holds wrong-path fetches, so hazard stalls and EX branches are moot here.
        if (mem_stall_s) begin
          pipe_s      = PIPE_FREEZE;
          ret_nxt_s   = ST_REDIR;
          state_nxt_s = ST_MEMWAIT;
          wait_nxt_s  = WAIT_ONE;
        end else begin
          pipe_s.ifid_flush = 1'b1;
          redir_nxt_s       = redir_cnt_r - 2'd1;
          if (redir_cnt_r == 2'd1) begin
            state_nxt_s = ST_RUN;
          end else begin
            state_nxt_s = ST_REDIR;
          end
        end
      end
      ST_MEMWAIT: begin
        if (ctl.dmem_ready) begin
          pipe_s      = PIPE_RUN;
          wait_nxt_s  = {WAIT_W{1'b0}};
          state_nxt_s = ret_r;
        end else if (wait_cnt_r == WAIT_LAST) begin
          pipe_s      = PIPE_FREEZE;
          state_nxt_s = ST_ERR;
          err_nxt_s   = 1'b1;
        end else begin
          pipe_s      = PIPE_FREEZE;
          wait_nxt_s  = wait_cnt_r + WAIT_ONE;
        end
      end
      ST_ERR: begin
        pipe_s    = PIPE_FREEZE;
        err_nxt_s = 1'b1;
      end
      default: begin
        pipe_s      = PIPE_FREEZE;
        state_nxt_s = ST_RUN;
      end
    endcase
  end

  assign pipe_out_s  = rst_n ? pipe_s : PIPE_RESET;
  assign stall_inc_s = rst_n & ~pipe_out_s.pc_en;

  // Sequencer state, redirect/wait counts and the sticky timeout flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_RUN;
      ret_r       <= ST_RUN;
      redir_cnt_r <= 2'd0;
      wait_cnt_r  <= {WAIT_W{1'b0}};
      err_r       <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      ret_r       <= ret_nxt_s;
      redir_cnt_r <= redir_nxt_s;
      wait_cnt_r  <= wait_nxt_s;
      err_r       <= err_nxt_s;
    end
  end

  pipeline_ctrl_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_inc_s),
    .q     (stall_cnt_s)
  );

  pipeline_ctrl_sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush_inc_s),
    .q     (flush_cnt_s)
  );

  pipeline_ctrl_checker u_checker (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_memwait (state_r == ST_MEMWAIT),
    .mem_req    (ctl.mem_req),
    .dmem_ready (ctl.dmem_ready)
  );

  assign ctl.pc_en       = pipe_out_s.pc_en;
  assign ctl.pc_redirect = pipe_out_s.pc_redirect;
  assign ctl.ifid_en     = pipe_out_s.ifid_en;
  assign ctl.ifid_flush  = pipe_out_s.ifid_flush;
  assign ctl.idex_en     = pipe_out_s.idex_en;
  assign ctl.idex_flush  = pipe_out_s.idex_flush;
  assign ctl.exmem_en    = pipe_out_s.exmem_en;
  assign ctl.memwb_en    = pipe_out_s.memwb_en;
  assign ctl.err         = err_r;
  assign ctl.stall_cnt   = stall_cnt_s;
  assign ctl.flush_cnt   = flush_cnt_s;

endmodule
